// File: rtl/fifo_rr_arb_pkg.sv
// rtl/fifo_rr_arb_pkg.sv - shared FSM encoding and helpers for the round-robin slot arbiter
package fifo_rr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/fifo_rr_arb_rr_pick.sv
// rtl/fifo_rr_arb_rr_pick.sv - rotate-and-priority-encode: first set req bit at or above ptr, wrapping
module rr_pick
    import fifo_rr_arb_pkg::*;
#(
    parameter int n = 4,
    parameter int w = clog2(n)
) (
    input  logic [n-1:0] req,
    input  logic [w-1:0] ptr,
    output logic         valid,
    output logic [w-1:0] idx
);

    int           pos;
    logic [n-1:0] shifted;

    // Walk the offsets downward so the smallest offset from ptr is written last and wins.
    always_comb begin
        valid   = 1'b0;
        idx     = '0;
        pos     = 0;
        shifted = '0;
        for (int k = n - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= n) begin
                pos = pos - n;
            end
            shifted = req >> pos;
            if (shifted[0]) begin
                valid = 1'b1;
                idx   = w'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arb.sv
// rtl/fifo_rr_arb.sv - single-slot buffer fed by a round-robin arbiter with burst locking
module fifo_rr_arb
    import fifo_rr_arb_pkg::*;
#(
    parameter int width = 1,
    parameter int nreq  = 4,
    parameter int idw   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [nreq-1:0]         req,
    input  logic [nreq-1:0]         last,
    input  logic [nreq*width-1:0]   d_in,
    output logic [nreq-1:0]         gnt,
    output logic [width-1:0]        d_out,
    output logic [idw-1:0]          owner,
    output logic                    empty_n,
    input  logic                    deq,
    input  logic                    clr
);

    arb_state_t     state, state_next;
    logic [idw-1:0] ptr;
    logic [idw-1:0] lock_id;
    logic [idw-1:0] win;
    logic           win_valid;
    logic           cap;
    logic           accept;
    logic [nreq-1:0] lock_mask;
    logic [nreq-1:0] cand;

    // While a burst is in flight only the lock holder may compete.
    assign lock_mask = {{(nreq-1){1'b0}}, 1'b1} << lock_id;
    assign cand      = (state == LOCKED) ? (req & lock_mask) : req;

    rr_pick #(
        .n (nreq),
        .w (idw)
    ) u_pick (
        .req   (cand),
        .ptr   (ptr),
        .valid (win_valid),
        .idx   (win)
    );

    assign cap    = !empty_n || deq;
    assign accept = win_valid && cap && !clr && !rst;
    assign gnt    = accept ? ({{(nreq-1){1'b0}}, 1'b1} << win) : '0;

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else if (accept) begin
            if (state == IDLE && !last[win]) begin
                state_next = LOCKED;
            end else if (state == LOCKED && last[win]) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_n <= 1'b0;
            owner   <= '0;
            ptr     <= '0;
            lock_id <= '0;
        end else begin
            if (clr) begin
                empty_n <= 1'b0;
            end else if (accept) begin
                empty_n <= 1'b1;
            end else if (deq) begin
                empty_n <= 1'b0;
            end
            if (accept) begin
                owner <= win;
            end
            // The pointer only advances on burst starts so a locked burst cannot skew fairness.
            if (accept && state == IDLE) begin
                lock_id <= win;
                ptr     <= (win == idw'(nreq - 1)) ? '0 : win + idw'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            d_out <= d_in[win*width +: width];
        end
    end

endmodule
